alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (>= 4, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), width of shift-amount field taken from B[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 op  input  4  operation select.
REQ-010 out_valid  output  1  Result/flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 Result  output  WIDTH  registered result.
REQ-013 Zero, Carry, Overflow, Negative  output  1 each  registered flags.
REQ-014 busy  output  1  high in EXEC state.

Function
REQ-015 Request accepted on any edge where in_valid && in_ready; A, B, op captured into internal registers on that edge.
REQ-016 FSM states IDLE, EXEC, DONE; IDLE->DONE for single-cycle ops, IDLE->EXEC for iterative ops with nonzero count, EXEC->DONE when count reaches 0, DONE->IDLE on out_ready without new accept.
REQ-017 in_ready = (state==IDLE) || (state==DONE && out_ready); accept in DONE goes directly to DONE or EXEC (back-to-back).
REQ-018 out_valid high exactly in DONE; Result and flags held stable while out_valid && !out_ready.
REQ-019 op 0..7: AND, OR, XOR, ADD, SUB, INC, DEC, SHL1; result/flag semantics of the 8-bit ALU generalised to WIDTH (SUB/DEC Carry = not-borrow-bit inverted, i.e. 1 on borrow; SHL1 Carry = A[MSB], Overflow = A[MSB]^A[MSB-1]).
REQ-020 op 8 ADC: A+B+stored Carry flag; Carry/Overflow per ADD rule.
REQ-021 op 9 SHR, 10 SAR, 11 ROL: shift/rotate A by k=B[SHW-1:0], one bit per cycle in EXEC; Carry = last bit shifted/rotated out, 0 when k=0; Overflow = 0.
REQ-022 op 12 MUL: unsigned shift-add, exactly WIDTH EXEC cycles; Result = low WIDTH bits; Carry = Overflow = (high WIDTH bits != 0).
REQ-023 op 13..15 illegal: Result 0, Zero 1, other flags 0, single-cycle.
REQ-024 Latency from accept edge N: single-cycle ops and k=0 shifts out_valid at N+1; shifts at N+1+k; MUL at N+1+WIDTH.
REQ-025 Zero = (Result==0), Negative = Result[WIDTH-1] for every op.
REQ-026 Stored Carry for ADC updates only when a result enters DONE.
REQ-027 Inputs ignored while in_ready low; in_valid during EXEC is not queued.

Reset
REQ-028 While reset high at an edge: state IDLE, out_valid 0, Result 0, Zero 1, Carry/Overflow/Negative 0, stored carry 0, counter 0, busy 0.
REQ-029 Reset mid-EXEC or in DONE aborts the operation; no result is delivered.
REQ-030 in_ready is 1 in the first cycle after reset deasserts.

Structure
REQ-031 Shared package alu_pkg holds op enum (4-bit), FSM state enum, and illegal-op constant.
REQ-032 One sub-module alu_mc_comb: combinational single-cycle datapath (ops 0..8, 13..15) returning result, carry, overflow.
REQ-033 Iterative shifter/multiplier datapath and FSM live in alu_mc; no other sub-modules.

Verification
REQ-034 WIDTH=8, ADD A=0x7F B=0x01 -> at N+1 Result 0x80, Overflow 1, Negative 1, Carry 0, Zero 0.
REQ-035 ADD 0xFF+0x01 then ADC 0x00+0x00 -> first Result 0x00 Carry 1 Zero 1; second Result 0x01.
REQ-036 SAR A=0x90 k=3 -> out_valid at N+4, Result 0xF2, Carry 0, busy high cycles N+1..N+3.
REQ-037 MUL A=0x10 B=0x20 -> out_valid at N+9, Result 0x00, Carry 1, Overflow 1, Zero 1.
REQ-038 out_ready low 5 cycles after XOR result -> Result/flags stable, in_ready 0; out_ready 1 with in_valid 1 -> back-to-back accept same edge.
REQ-039 reset asserted at EXEC cycle 3 of MUL -> next cycle out_valid 0, Result 0, Zero 1, in_ready 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states,
// the first illegal opcode, and a helper that picks out the iterative ops.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_INC  = 4'd5,
        OP_DEC  = 4'd6,
        OP_SHL1 = 4'd7,
        OP_ADC  = 4'd8,
        OP_SHR  = 4'd9,
        OP_SAR  = 4'd10,
        OP_ROL  = 4'd11,
        OP_MUL  = 4'd12,
        OP_IL13 = 4'd13,
        OP_IL14 = 4'd14,
        OP_IL15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Opcodes at or above this value are illegal.
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd13;

    // Shifts, rotate and multiply run one step per cycle in EXEC.
    function automatic logic is_iter_op(input logic [3:0] f_op);
        return (f_op == OP_SHR) || (f_op == OP_SAR) ||
               (f_op == OP_ROL) || (f_op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// Single-cycle datapath: logic ops, add/sub family, SHL1 and ADC.
// Iterative and illegal opcodes return an all-zero result and flags.
module alu_mc_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int M = WIDTH - 1;

    logic [WIDTH:0] w_sum;

    // Result and carry/overflow for every single-cycle opcode.
    always_comb begin
        w_sum      = '0;
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_op)
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_ADD: begin
                w_sum      = {1'b0, i_a} + {1'b0, i_b};
                o_result   = w_sum[M:0];
                o_carry    = w_sum[WIDTH];
                o_overflow = (i_a[M] == i_b[M]) && (w_sum[M] != i_a[M]);
            end
            OP_SUB: begin
                // Top bit of the extended difference is the borrow.
                w_sum      = {1'b0, i_a} - {1'b0, i_b};
                o_result   = w_sum[M:0];
                o_carry    = w_sum[WIDTH];
                o_overflow = (i_a[M] != i_b[M]) && (w_sum[M] != i_a[M]);
            end
            OP_INC: begin
                w_sum      = {1'b0, i_a} + (WIDTH+1)'(1);
                o_result   = w_sum[M:0];
                o_carry    = w_sum[WIDTH];
                o_overflow = !i_a[M] && w_sum[M];
            end
            OP_DEC: begin
                w_sum      = {1'b0, i_a} - (WIDTH+1)'(1);
                o_result   = w_sum[M:0];
                o_carry    = w_sum[WIDTH];
                o_overflow = i_a[M] && !w_sum[M];
            end
            OP_SHL1: begin
                o_result   = {i_a[M-1:0], 1'b0};
                o_carry    = i_a[M];
                o_overflow = i_a[M] ^ i_a[M-1];
            end
            OP_ADC: begin
                w_sum      = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
                o_result   = w_sum[M:0];
                o_carry    = w_sum[WIDTH];
                o_overflow = (i_a[M] == i_b[M]) && (w_sum[M] != i_a[M]);
            end
            default: begin
                o_result   = '0;
                o_carry    = 1'b0;
                o_overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle
// ops come from alu_mc_comb; shifts, rotate and multiply iterate in EXEC.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative,
    output logic             busy
);

    localparam int M  = WIDTH - 1;
    localparam int CW = SHW + 1;   // must hold WIDTH for MUL

    alu_state_e       r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_work;      // shift operand, or MUL multiplier/low product
    logic [WIDTH-1:0] r_acc;       // MUL high product
    logic [WIDTH-1:0] r_mcand;     // MUL multiplicand
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_carry, r_ovf, r_neg;
    logic             r_out_valid, r_busy;

    logic             w_accept;
    logic [SHW-1:0]   w_k;
    logic             w_go_exec;
    logic [WIDTH-1:0] w_c_res;
    logic             w_c_c, w_c_v;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_nx_work, w_nx_acc;
    logic             w_nx_c, w_nx_v;
    logic [WIDTH-1:0] w_ld_res;
    logic             w_ld_c, w_ld_v;

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_k       = B[SHW-1:0];
    assign w_go_exec = is_iter_op(op) && ((op == OP_MUL) || (w_k != '0));

    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign Result    = r_result;
    assign Zero      = r_zero;
    assign Carry     = r_carry;
    assign Overflow  = r_ovf;
    assign Negative  = r_neg;

    alu_mc_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .i_a        (A),
        .i_b        (B),
        .i_op       (op),
        .i_cin      (r_carry),
        .o_result   (w_c_res),
        .o_carry    (w_c_c),
        .o_overflow (w_c_v)
    );

    // One iteration step of the active shift/rotate/multiply.
    always_comb begin
        w_sum     = '0;
        w_nx_work = r_work;
        w_nx_acc  = r_acc;
        w_nx_c    = 1'b0;
        case (r_op)
            OP_SHR: begin
                w_nx_c    = r_work[0];
                w_nx_work = {1'b0, r_work[M:1]};
            end
            OP_SAR: begin
                w_nx_c    = r_work[0];
                w_nx_work = {r_work[M], r_work[M:1]};
            end
            OP_ROL: begin
                w_nx_c    = r_work[M];
                w_nx_work = {r_work[M-1:0], r_work[M]};
            end
            OP_MUL: begin
                // Add multiplicand into the high half when the multiplier
                // LSB is set, then shift the {acc, work} pair right by one.
                w_sum     = {1'b0, r_acc} + (r_work[0] ? {1'b0, r_mcand} : '0);
                w_nx_acc  = w_sum[WIDTH:1];
                w_nx_work = {w_sum[0], r_work[M:1]};
                w_nx_c    = (w_nx_acc != '0);
            end
            default: begin
                w_nx_work = r_work;
                w_nx_acc  = r_acc;
                w_nx_c    = 1'b0;
            end
        endcase
        w_nx_v = (r_op == OP_MUL) ? w_nx_c : 1'b0;
    end

    // Select the payload that enters DONE on this edge.
    always_comb begin
        if (r_state == ST_EXEC) begin
            w_ld_res = w_nx_work;
            w_ld_c   = w_nx_c;
            w_ld_v   = w_nx_v;
        end else if (is_iter_op(op)) begin
            // Zero-count shift: operand passes through, nothing shifted out.
            w_ld_res = A;
            w_ld_c   = 1'b0;
            w_ld_v   = 1'b0;
        end else begin
            w_ld_res = w_c_res;
            w_ld_c   = w_c_c;
            w_ld_v   = w_c_v;
        end
    end

    // Control FSM with the iterative datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_work      <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_mcand <= A;
                        r_acc   <= '0;
                        if (w_go_exec) begin
                            r_state     <= ST_EXEC;
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_work      <= (op == OP_MUL) ? B : A;
                            r_cnt       <= (op == OP_MUL) ? CW'(WIDTH) : {1'b0, w_k};
                        end else begin
                            r_state     <= ST_DONE;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_work      <= A;
                            r_result    <= w_ld_res;
                            r_zero      <= (w_ld_res == '0);
                            r_neg       <= w_ld_res[M];
                            r_carry     <= w_ld_c;
                            r_ovf       <= w_ld_v;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    r_work <= w_nx_work;
                    r_acc  <= w_nx_acc;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_result    <= w_ld_res;
                        r_zero      <= (w_ld_res == '0);
                        r_neg       <= w_ld_res[M];
                        r_carry     <= w_ld_c;
                        r_ovf       <= w_ld_v;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8 with hand-computed expectations.
module tb_alu_mc;
    import alu_pkg::*;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Result;
    logic       Zero, Carry, Overflow, Negative;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_mc #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .Carry     (Carry),
        .Overflow  (Overflow),
        .Negative  (Negative),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for the result, check latency, result and ZCVN.
    task automatic run_op(input string tag, input logic [3:0] f_op, input logic [7:0] a,
                          input logic [7:0] b, input int lat, input logic [7:0] res,
                          input logic [3:0] zcvn);
        int n;
        op = f_op; A = a; B = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            check({tag, "_busy"}, busy, 1);
            n++;
            tick();
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_res"}, Result, res);
        check({tag, "_zcvn"}, {Zero, Carry, Overflow, Negative}, zcvn);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; op = '0;
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_res", Result, 0);
        check("rst_zcvn", {Zero, Carry, Overflow, Negative}, 4'b1000);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        check("rst_ready", in_ready, 1);

        run_op("add_ovf",  OP_ADD,  8'h7F, 8'h01, 0, 8'h80, 4'b0011);
        run_op("add_cy",   OP_ADD,  8'hFF, 8'h01, 0, 8'h00, 4'b1100);
        run_op("adc_c1",   OP_ADC,  8'h00, 8'h00, 0, 8'h01, 4'b0000);
        run_op("sub_brw",  OP_SUB,  8'h10, 8'h20, 0, 8'hF0, 4'b0101);
        run_op("sub_ovf",  OP_SUB,  8'h80, 8'h01, 0, 8'h7F, 4'b0010);
        run_op("dec_0",    OP_DEC,  8'h00, 8'h00, 0, 8'hFF, 4'b0101);
        run_op("inc_ff",   OP_INC,  8'hFF, 8'h00, 0, 8'h00, 4'b1100);
        run_op("shl_c",    OP_SHL1, 8'hC0, 8'h00, 0, 8'h80, 4'b0101);
        run_op("shl_v",    OP_SHL1, 8'h40, 8'h00, 0, 8'h80, 4'b0011);
        run_op("and",      OP_AND,  8'hF0, 8'h3C, 0, 8'h30, 4'b0000);
        run_op("or",       OP_OR,   8'h0F, 8'hF0, 0, 8'hFF, 4'b0001);
        run_op("xor_z",    OP_XOR,  8'hAA, 8'hAA, 0, 8'h00, 4'b1000);
        run_op("sar3",     OP_SAR,  8'h90, 8'h03, 3, 8'hF2, 4'b0001);
        run_op("shr1",     OP_SHR,  8'h81, 8'h01, 1, 8'h40, 4'b0100);
        run_op("rol2",     OP_ROL,  8'h81, 8'h02, 2, 8'h06, 4'b0000);
        run_op("shr0",     OP_SHR,  8'h85, 8'h08, 0, 8'h85, 4'b0001);
        run_op("mul_hi",   OP_MUL,  8'h10, 8'h20, 8, 8'h00, 4'b1110);
        run_op("mul_lo",   OP_MUL,  8'h0F, 8'h0E, 8, 8'hD2, 4'b0001);
        run_op("illegal",  4'd13,   8'hFF, 8'hFF, 0, 8'h00, 4'b1000);
        run_op("adc_c0",   OP_ADC,  8'hFF, 8'h01, 0, 8'h00, 4'b1100);
        run_op("adc_c1b",  OP_ADC,  8'h00, 8'h00, 0, 8'h01, 4'b0000);

        // Backpressure: result held, new requests refused, then back-to-back accept.
        tick();
        out_ready = 1'b0;
        op = OP_XOR; A = 8'h5A; B = 8'h0F; in_valid = 1'b1;
        tick();
        op = OP_AND; A = 8'hFF; B = 8'h00;
        check("hold_v0", out_valid, 1);
        check("hold_r0", Result, 8'h55);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_v", out_valid, 1);
            check("hold_r", Result, 8'h55);
            check("hold_f", {Zero, Carry, Overflow, Negative}, 4'b0000);
            check("hold_rdy", in_ready, 0);
        end
        op = OP_ADD; A = 8'h01; B = 8'h02; out_ready = 1'b1;
        #1;
        check("b2b_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("b2b_v", out_valid, 1);
        check("b2b_r", Result, 8'h03);

        // Reset during the third EXEC cycle of a multiply.
        op = OP_MUL; A = 8'h10; B = 8'h20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("abort_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("abort_v", out_valid, 0);
        check("abort_r", Result, 0);
        check("abort_z", Zero, 1);
        check("abort_rdy", in_ready, 1);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("abort_nores", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
